// File: rtl/dec_stage_if.sv
// Handshake and data bundle between IF/ID, the register file, EX and the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface dec_stage_if #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned PC_WIDTH      = 32,
   parameter int unsigned REG_IDX_WIDTH = 5
);
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [31:0]              instr_i;
   logic [PC_WIDTH-1:0]      pc_i;
   logic                     flush_i;
   logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_o;
   logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_o;
   logic                     dec_rs1_en_o;
   logic                     dec_rs2_en_o;
   logic [XLEN-1:0]          dec_rs1_i;
   logic [XLEN-1:0]          dec_rs2_i;
   logic                     ex_load_i;
   logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [PC_WIDTH-1:0]      out_pc_o;
   logic [XLEN-1:0]          out_op1_o;
   logic [XLEN-1:0]          out_op2_o;
   logic [XLEN-1:0]          out_imm_o;
   logic [XLEN-1:0]          out_rs1_o;
   logic [XLEN-1:0]          out_rs2_o;
   logic [3:0]               out_alu_fun_o;
   logic [REG_IDX_WIDTH-1:0] out_rd_idx_o;
   logic                     out_rd_en_o;
   logic                     out_is_branch_o;
   logic                     out_is_jal_o;
   logic                     out_is_jalr_o;
   logic                     out_is_load_o;
   logic                     out_is_store_o;
   logic                     out_illegal_o;
   logic [2:0]               out_fun3_o;
   logic [31:0]              stall_cnt_o;

   modport slave (
      input  in_valid_i, instr_i, pc_i, flush_i, dec_rs1_i, dec_rs2_i, ex_load_i, ex_rd_idx_i,
             out_ready_i,
      output in_ready_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rs1_en_o, dec_rs2_en_o, out_valid_o,
             out_pc_o, out_op1_o, out_op2_o, out_imm_o, out_rs1_o, out_rs2_o, out_alu_fun_o,
             out_rd_idx_o, out_rd_en_o, out_is_branch_o, out_is_jal_o, out_is_jalr_o,
             out_is_load_o, out_is_store_o, out_illegal_o, out_fun3_o, stall_cnt_o
   );

   modport master (
      output in_valid_i, instr_i, pc_i, flush_i, dec_rs1_i, dec_rs2_i, ex_load_i, ex_rd_idx_i,
             out_ready_i,
      input  in_ready_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rs1_en_o, dec_rs2_en_o, out_valid_o,
             out_pc_o, out_op1_o, out_op2_o, out_imm_o, out_rs1_o, out_rs2_o, out_alu_fun_o,
             out_rd_idx_o, out_rd_en_o, out_is_branch_o, out_is_jal_o, out_is_jalr_o,
             out_is_load_o, out_is_store_o, out_illegal_o, out_fun3_o, stall_cnt_o
   );
endinterface

// File: rtl/dec_stage.sv
// Registered RV32I decode stage: operand assembly, illegal-encoding detection,
// valid/ready handshake with load-use stall, flush and a saturating stall counter.
module dec_stage #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned PC_WIDTH      = 32,
   parameter int unsigned REG_IDX_WIDTH = 5
) (
   input logic        clk,
   input logic        rst,
   dec_stage_if.slave bus
);
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluSll  = 4'd2;
   localparam logic [3:0] AluSlt  = 4'd3;
   localparam logic [3:0] AluSltu = 4'd4;
   localparam logic [3:0] AluXor  = 4'd5;
   localparam logic [3:0] AluSrl  = 4'd6;
   localparam logic [3:0] AluSra  = 4'd7;
   localparam logic [3:0] AluOr   = 4'd8;
   localparam logic [3:0] AluAnd  = 4'd9;

   typedef struct packed {
      logic [PC_WIDTH-1:0]      pc;
      logic [XLEN-1:0]          op1;
      logic [XLEN-1:0]          op2;
      logic [XLEN-1:0]          imm;
      logic [XLEN-1:0]          rs1;
      logic [XLEN-1:0]          rs2;
      logic [3:0]               alu_fun;
      logic [REG_IDX_WIDTH-1:0] rd_idx;
      logic                     rd_en;
      logic                     is_branch;
      logic                     is_jal;
      logic                     is_jalr;
      logic                     is_load;
      logic                     is_store;
      logic                     illegal;
      logic [2:0]               fun3;
   } bundle_t;

   logic [31:0]              instr;
   logic [6:0]               opcode;
   logic [6:0]               fun7;
   logic [2:0]               fun3;
   logic [REG_IDX_WIDTH-1:0] rs1_idx;
   logic [REG_IDX_WIDTH-1:0] rs2_idx;
   logic [XLEN-1:0]          imm_i, imm_s, imm_b, imm_u, imm_j, pc_ext;
   logic [3:0]               alu_sel;
   logic                     rs1_en, rs2_en, rd_wr, bad;
   logic                     hazard, in_ready, accept;
   bundle_t                  dec;
   bundle_t                  bundle_q;
   logic                     valid_q;
   logic [31:0]              stall_q;

   assign instr   = bus.instr_i;
   assign opcode  = instr[6:0];
   assign fun3    = instr[14:12];
   assign fun7    = instr[31:25];
   assign rs1_idx = REG_IDX_WIDTH'(instr[19:15]);
   assign rs2_idx = REG_IDX_WIDTH'(instr[24:20]);

   assign imm_i  = XLEN'($signed(instr[31:20]));
   assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
   assign pc_ext = XLEN'(bus.pc_i);

   // Shared fun3 map for R-type and I-ALU; SUB only exists in the R-type encoding.
   always_comb begin
      alu_sel = AluAdd;
      case (fun3)
         3'b000: alu_sel = (opcode == OpReg && fun7 == 7'b0100000) ? AluSub : AluAdd;
         3'b001: alu_sel = AluSll;
         3'b010: alu_sel = AluSlt;
         3'b011: alu_sel = AluSltu;
         3'b100: alu_sel = AluXor;
         3'b101: alu_sel = fun7[5] ? AluSra : AluSrl;
         3'b110: alu_sel = AluOr;
         3'b111: alu_sel = AluAnd;
      endcase
   end

   always_comb begin
      dec        = '0;
      rs1_en     = 1'b0;
      rs2_en     = 1'b0;
      rd_wr      = 1'b0;
      bad        = 1'b0;
      dec.pc     = bus.pc_i;
      dec.rs1    = bus.dec_rs1_i;
      dec.rs2    = bus.dec_rs2_i;
      dec.rd_idx = REG_IDX_WIDTH'(instr[11:7]);
      dec.fun3   = fun3;
      case (opcode)
         OpReg: begin
            {rs1_en, rs2_en, rd_wr} = 3'b111;
            dec.op1     = bus.dec_rs1_i;
            dec.op2     = bus.dec_rs2_i;
            dec.alu_fun = alu_sel;
            bad = !(fun7 == 7'b0 || (fun7 == 7'b0100000 && (fun3 == 3'b000 || fun3 == 3'b101)));
         end
         OpImm: begin
            {rs1_en, rd_wr} = 2'b11;
            dec.op1     = bus.dec_rs1_i;
            dec.op2     = imm_i;
            dec.imm     = imm_i;
            dec.alu_fun = alu_sel;
            bad = (fun3 == 3'b001 && fun7 != 7'b0) ||
                  (fun3 == 3'b101 && fun7 != 7'b0 && fun7 != 7'b0100000);
         end
         OpLoad: begin
            {rs1_en, rd_wr} = 2'b11;
            dec.is_load = 1'b1;
            dec.op1     = bus.dec_rs1_i;
            dec.op2     = imm_i;
            dec.imm     = imm_i;
            bad         = (fun3 == 3'b011) || (fun3[2:1] == 2'b11);
         end
         OpStore: begin
            {rs1_en, rs2_en} = 2'b11;
            dec.is_store = 1'b1;
            dec.op1      = bus.dec_rs1_i;
            dec.op2      = imm_s;
            dec.imm      = imm_s;
            bad          = fun3 > 3'b010;
         end
         OpBranch: begin
            {rs1_en, rs2_en} = 2'b11;
            dec.is_branch = 1'b1;
            dec.op1       = bus.dec_rs1_i;
            dec.op2       = bus.dec_rs2_i;
            dec.imm       = imm_b;
            bad           = fun3[2:1] == 2'b01;
         end
         OpJal: begin
            rd_wr      = 1'b1;
            dec.is_jal = 1'b1;
            dec.op1    = pc_ext;
            dec.op2    = XLEN'(4);
            dec.imm    = imm_j;
         end
         OpJalr: begin
            {rs1_en, rd_wr} = 2'b11;
            dec.is_jalr = 1'b1;
            dec.op1     = pc_ext;
            dec.op2     = XLEN'(4);
            dec.imm     = imm_i;
            bad         = fun3 != 3'b000;
         end
         OpLui: begin
            rd_wr   = 1'b1;
            dec.op2 = imm_u;
            dec.imm = imm_u;
         end
         OpAuipc: begin
            rd_wr   = 1'b1;
            dec.op1 = pc_ext;
            dec.op2 = imm_u;
            dec.imm = imm_u;
         end
         default: bad = 1'b1;
      endcase
      // Illegal encodings travel down the pipe as an inert ADD 0,0 with only the flag set.
      if (bad) begin
         {rs1_en, rs2_en, rd_wr} = 3'b000;
         {dec.is_branch, dec.is_jal, dec.is_jalr, dec.is_load, dec.is_store} = 5'b0;
         dec.op1     = '0;
         dec.op2     = '0;
         dec.imm     = '0;
         dec.alu_fun = AluAdd;
      end
      dec.illegal = bad;
      dec.rd_en   = rd_wr && (instr[11:7] != 5'd0);
   end

   assign hazard = bus.in_valid_i && bus.ex_load_i && (bus.ex_rd_idx_i != '0) &&
                   ((rs1_en && rs1_idx == bus.ex_rd_idx_i) || (rs2_en && rs2_idx == bus.ex_rd_idx_i));
   assign in_ready = (!valid_q || bus.out_ready_i) && !hazard && !bus.flush_i;
   assign accept   = bus.in_valid_i && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         stall_q  <= '0;
      end else begin
         if (hazard && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (bus.flush_i) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
         end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready_o      = in_ready;
   assign bus.dec_rs1_idx_o   = rs1_idx;
   assign bus.dec_rs2_idx_o   = rs2_idx;
   assign bus.dec_rs1_en_o    = rs1_en;
   assign bus.dec_rs2_en_o    = rs2_en;
   assign bus.out_valid_o     = valid_q;
   assign bus.out_pc_o        = bundle_q.pc;
   assign bus.out_op1_o       = bundle_q.op1;
   assign bus.out_op2_o       = bundle_q.op2;
   assign bus.out_imm_o       = bundle_q.imm;
   assign bus.out_rs1_o       = bundle_q.rs1;
   assign bus.out_rs2_o       = bundle_q.rs2;
   assign bus.out_alu_fun_o   = bundle_q.alu_fun;
   assign bus.out_rd_idx_o    = bundle_q.rd_idx;
   assign bus.out_rd_en_o     = bundle_q.rd_en;
   assign bus.out_is_branch_o = bundle_q.is_branch;
   assign bus.out_is_jal_o    = bundle_q.is_jal;
   assign bus.out_is_jalr_o   = bundle_q.is_jalr;
   assign bus.out_is_load_o   = bundle_q.is_load;
   assign bus.out_is_store_o  = bundle_q.is_store;
   assign bus.out_illegal_o   = bundle_q.illegal;
   assign bus.out_fun3_o      = bundle_q.fun3;
   assign bus.stall_cnt_o     = stall_q;
endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed steps followed by random traffic, all outputs
// compared each cycle against a behavioural decode/pipeline reference model.
module tb_dec_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dec_stage_if #(.XLEN(32), .PC_WIDTH(32), .REG_IDX_WIDTH(5)) bus ();
   dec_stage #(.XLEN(32), .PC_WIDTH(32), .REG_IDX_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] pc, op1, op2, imm, rs1, rs2;
      logic [3:0]  alu;
      logic [4:0]  rd_idx;
      logic        rd_en, br, jal, jalr, ld, st, ill;
      logic [2:0]  f3;
      logic        rs1_en, rs2_en;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        m_b;
   logic        m_valid;
   logic [31:0] m_stall;
   logic        m_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode: immediates from arithmetic shifts, ALU code from a fun3 table.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [31:0] ii, si, bi, ui, ji;
      int          sx, t;
      int          base [8];
      logic        legal, r1, r2, rw, alu_op;
      base = '{0, 2, 3, 4, 5, 6, 8, 9};
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      sx = ins;
      ii = sx >>> 20;
      t  = sx >>> 25;
      si = (t << 5) | ((ins >> 7) & 32'h1F);
      t  = sx >>> 31;
      bi = (t << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5) |
           (((ins >> 8) & 32'hF) << 1);
      ji = (t << 20) | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11) |
           (((ins >> 21) & 32'h3FF) << 1);
      ui = ins & 32'hFFFFF000;
      e = '0;
      e.pc = pc;
      e.rs1 = a;
      e.rs2 = b;
      e.rd_idx = ins[11:7];
      e.f3 = f3;
      legal = 1'b1;
      {r1, r2, rw, alu_op} = 4'b0;
      case (op)
         7'h33: begin legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            {r1, r2, rw, alu_op} = 4'b1111; e.op1 = a; e.op2 = b; end
         7'h13: begin legal = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20));
            {r1, rw, alu_op} = 3'b111; e.op1 = a; e.op2 = ii; e.imm = ii; end
         7'h03: begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            {r1, rw, e.ld} = 3'b111; e.op1 = a; e.op2 = ii; e.imm = ii; end
         7'h23: begin legal = f3 <= 2; {r1, r2, e.st} = 3'b111; e.op1 = a; e.op2 = si;
            e.imm = si; end
         7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); {r1, r2, e.br} = 3'b111;
            e.op1 = a; e.op2 = b; e.imm = bi; end
         7'h6F: begin {rw, e.jal} = 2'b11; e.op1 = pc; e.op2 = 4; e.imm = ji; end
         7'h67: begin legal = f3 == 0; {r1, rw, e.jalr} = 3'b111; e.op1 = pc; e.op2 = 4;
            e.imm = ii; end
         7'h37: begin rw = 1'b1; e.op2 = ui; e.imm = ui; end
         7'h17: begin rw = 1'b1; e.op1 = pc; e.op2 = ui; e.imm = ui; end
         default: legal = 1'b0;
      endcase
      if (alu_op) begin
         e.alu = 4'(base[f3]);
         if (f3 == 0 && op == 7'h33 && f7 == 7'h20) e.alu = 4'd1;
         if (f3 == 5 && f7[5]) e.alu = 4'd7;
      end
      if (!legal) begin
         {r1, r2, rw, e.br, e.jal, e.jalr, e.ld, e.st} = '0;
         e.op1 = 0; e.op2 = 0; e.imm = 0; e.alu = 0;
      end
      e.ill = !legal;
      e.rs1_en = r1;
      e.rs2_en = r2;
      e.rd_en = rw && (ins[11:7] != 0);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [9];
      logic [31:0] w;
      int          k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      w = $urandom;
      k = $urandom_range(0, 9);
      w[6:0] = (k == 9) ? 7'($urandom) : ops[k];
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      w[11:7] = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      if (w[6:0] == 7'h67 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
      return w;
   endfunction

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      exp_t e;
      logic hz;
      #1;
      e = model(bus.instr_i, bus.pc_i, bus.dec_rs1_i, bus.dec_rs2_i);
      hz = bus.in_valid_i && bus.ex_load_i && bus.ex_rd_idx_i != 0 &&
           ((e.rs1_en && bus.instr_i[19:15] == bus.ex_rd_idx_i) ||
            (e.rs2_en && bus.instr_i[24:20] == bus.ex_rd_idx_i));
      m_rdy = (!m_valid || bus.out_ready_i) && !hz && !bus.flush_i;
      chk("in_ready", bus.in_ready_o, m_rdy);
      chk("rs1_en", bus.dec_rs1_en_o, e.rs1_en);
      chk("rs2_en", bus.dec_rs2_en_o, e.rs2_en);
      chk("rs1_idx", bus.dec_rs1_idx_o, bus.instr_i[19:15]);
      chk("rs2_idx", bus.dec_rs2_idx_o, bus.instr_i[24:20]);
      if (rst) begin
         m_valid = 1'b0;
         m_b = '0;
         m_stall = 0;
      end else begin
         if (hz && m_stall != 32'hFFFFFFFF) m_stall++;
         if (bus.flush_i) m_valid = 1'b0;
         else if (bus.in_valid_i && m_rdy) begin m_valid = 1'b1; m_b = e; end
         else if (bus.out_ready_i) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", bus.out_valid_o, m_valid);
      chk("pc", bus.out_pc_o, m_b.pc);
      chk("op1", bus.out_op1_o, m_b.op1);
      chk("op2", bus.out_op2_o, m_b.op2);
      chk("imm", bus.out_imm_o, m_b.imm);
      chk("rs1", bus.out_rs1_o, m_b.rs1);
      chk("rs2", bus.out_rs2_o, m_b.rs2);
      chk("alu_fun", bus.out_alu_fun_o, m_b.alu);
      chk("rd_idx", bus.out_rd_idx_o, m_b.rd_idx);
      chk("rd_en", bus.out_rd_en_o, m_b.rd_en);
      chk("flags", {bus.out_is_branch_o, bus.out_is_jal_o, bus.out_is_jalr_o,
                    bus.out_is_load_o, bus.out_is_store_o},
           {m_b.br, m_b.jal, m_b.jalr, m_b.ld, m_b.st});
      chk("illegal", bus.out_illegal_o, m_b.ill);
      chk("fun3", bus.out_fun3_o, m_b.f3);
      chk("stall_cnt", bus.stall_cnt_o, m_stall);
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      bus.instr_i = ins;
      bus.pc_i = pc;
      bus.in_valid_i = 1'b1;
   endtask

   initial begin
      m_valid = 1'b0;
      m_b = '0;
      m_stall = 0;
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      bus.instr_i = 32'h0;
      bus.pc_i = 32'h0;
      bus.flush_i = 1'b0;
      bus.dec_rs1_i = 32'h0;
      bus.dec_rs2_i = 32'h0;
      bus.ex_load_i = 1'b0;
      bus.ex_rd_idx_i = 5'd0;
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      chk("reset_valid", bus.out_valid_o, 1'b0);
      chk("reset_stall", bus.stall_cnt_o, 32'd0);
      rst = 1'b0;

      // ADDI x5,x1,-3
      bus.dec_rs1_i = 32'd10;
      bus.dec_rs2_i = 32'h55;
      offer(32'hFFD08293, 32'h100);
      cycle();
      chk("addi_valid", bus.out_valid_o, 1'b1);
      chk("addi_op1", bus.out_op1_o, 32'd10);
      chk("addi_op2", bus.out_op2_o, 32'hFFFFFFFD);
      chk("addi_alu", bus.out_alu_fun_o, 4'd0);
      chk("addi_rd", {bus.out_rd_idx_o, bus.out_rd_en_o}, {5'd5, 1'b1});

      // Back-pressure with ADD x3,x1,x2 on offer
      bus.out_ready_i = 1'b0;
      bus.dec_rs1_i = 32'h11;
      bus.dec_rs2_i = 32'h22;
      offer(32'h002081B3, 32'h104);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ready", bus.in_ready_o, 1'b0);
         chk("bp_op1_held", bus.out_op1_o, 32'd10);
      end
      bus.out_ready_i = 1'b1;
      cycle();
      chk("release_op1", bus.out_op1_o, 32'h11);

      // Load-use hazard on x1
      bus.ex_load_i = 1'b1;
      bus.ex_rd_idx_i = 5'd1;
      offer(32'h002081B3, 32'h108);
      cycle();
      chk("hz_bubble", bus.out_valid_o, 1'b0);
      chk("hz_stall", bus.stall_cnt_o, 32'd1);
      bus.ex_load_i = 1'b0;
      cycle();
      chk("hz_issue", {bus.out_valid_o, bus.out_op1_o, bus.out_op2_o}, {1'b1, 32'h11, 32'h22});

      // Flush of a held bundle while a new instruction is offered
      bus.out_ready_i = 1'b0;
      bus.flush_i = 1'b1;
      offer(32'hFFD08293, 32'h10C);
      cycle();
      chk("flush_valid", bus.out_valid_o, 1'b0);
      chk("flush_stall", bus.stall_cnt_o, 32'd1);
      bus.flush_i = 1'b0;
      bus.out_ready_i = 1'b1;

      offer(32'h0000007F, 32'h110);
      cycle();
      chk("ill_op", {bus.out_illegal_o, bus.out_rd_en_o}, 2'b10);
      offer(32'h400010B3, 32'h114);
      cycle();
      chk("ill_r", {bus.out_illegal_o, bus.out_rd_en_o, bus.out_is_load_o}, 3'b100);
      offer(32'h40415113, 32'h118);
      cycle();
      chk("srai", {bus.out_alu_fun_o, bus.out_op2_o[4:0]}, {4'd7, 5'd4});
      offer(32'h00513093, 32'h11C);
      cycle();
      chk("sltiu", bus.out_alu_fun_o, 4'd4);
      offer(32'h008000EF, 32'h200);
      cycle();
      chk("jal", {bus.out_op1_o, bus.out_op2_o, bus.out_imm_o, bus.out_rd_en_o},
          {32'h200, 32'd4, 32'd8, 1'b1});
      offer(32'h12345037, 32'h204);
      cycle();
      chk("lui", {bus.out_rd_en_o, bus.out_op2_o}, {1'b0, 32'h12345000});

      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         bus.in_valid_i = ($urandom_range(0, 9) < 7);
         bus.out_ready_i = ($urandom_range(0, 9) < 7);
         bus.flush_i = ($urandom_range(0, 9) == 0);
         bus.ex_load_i = ($urandom_range(0, 9) < 3);
         bus.ex_rd_idx_i = 5'($urandom_range(0, 3));
         bus.instr_i = rand_instr();
         bus.pc_i = $urandom;
         bus.dec_rs1_i = $urandom;
         bus.dec_rs2_i = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
